stopwatch_ctrl: RTL and testbench

- Sequencing controller for a chain of NDIG BCD digit counters (9-to-0 up/down T-flip-flop counters) that forms the stopwatch display value.
- Decodes start/stop/clear/preset commands and runs a run/pause/done state machine.
- Each cycle, drives every digit counter's 2-bit mode code, its 4-bit set bus and a shared active-low clear.
- Generates the decimal carry/borrow cascade from the digit values fed back from the counters.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/bcd_cascade.sv | 28 ++
 rtl/stopwatch_ctrl.sv | 124 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch digit-chain controller.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam logic [1:0] MODE_DOWN = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Saturate an out-of-range BCD nibble to 9.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_cascade.sv
// Decimal carry/borrow chain: which digits advance on this tick, and whether
// the whole chain sits at its terminal value (all nines up, all zeros down).
module bcd_cascade
    import stopwatch_pkg::*;
#(
    parameter int unsigned NDIG = 4
) (
    input  logic                  tick,
    input  logic                  up,
    input  logic [4*NDIG-1:0]     digit_q,
    output logic [NDIG-1:0]       adv_c,
    output logic                  term_c
);

    always_comb begin
        logic       carry;
        logic [3:0] edge_val;
        edge_val = up ? BCD_MAX : 4'd0;
        carry    = tick;
        adv_c    = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            adv_c[i] = carry;
            carry    = carry & (digit_q[4*i +: 4] == edge_val);
        end
        term_c = carry;
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: command decode, run/pause/done FSM and per-digit
// mode/set/clear drive for an external chain of BCD up/down counters.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned NDIG = 4,
    parameter bit          WRAP = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                load_req,
    input  logic                dir,
    input  logic [4*NDIG-1:0]   preset,
    input  logic [4*NDIG-1:0]   digit_q,
    output logic [2*NDIG-1:0]   digit_mode,
    output logic [4*NDIG-1:0]   digit_set,
    output logic                ctr_clr_n,
    output logic                running,
    output logic                done
);

    state_t          state, state_nxt;
    logic            dir_r, dir_nxt;
    logic            load_pend, load_pend_nxt;
    logic [NDIG-1:0] adv_c;
    logic            term_c;
    logic            count_en_c;
    logic            hold_term_c;

    bcd_cascade #(.NDIG(NDIG)) u_cascade (
        .tick    (tick),
        .up      (dir_r),
        .digit_q (digit_q),
        .adv_c   (adv_c),
        .term_c  (term_c)
    );

    // A tick only counts in RUN when no higher-priority command preempts it.
    assign count_en_c  = (state == RUN) && !clear && !stop;
    assign hold_term_c = term_c && (!dir_r || !WRAP);

    always_comb begin
        state_nxt     = state;
        dir_nxt       = dir_r;
        load_pend_nxt = load_pend;
        if (clear) begin
            state_nxt     = CLR;
            load_pend_nxt = 1'b0;
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    if (load_req) begin
                        state_nxt     = CLR;
                        load_pend_nxt = 1'b1;
                    end else if (start) begin
                        state_nxt = RUN;
                        dir_nxt   = dir;
                    end
                end
                CLR: begin
                    state_nxt     = load_pend ? LOAD : IDLE;
                    load_pend_nxt = 1'b0;
                end
                LOAD:    state_nxt = PAUSE;
                RUN: begin
                    if (stop)
                        state_nxt = PAUSE;
                    else if (hold_term_c)
                        state_nxt = DONE;
                end
                DONE: begin
                    if (start) begin
                        state_nxt = RUN;
                        dir_nxt   = dir;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counter drive is decoded from the registered state so a tick lands the same cycle.
    always_comb begin
        digit_mode = {NDIG{MODE_HOLD}};
        digit_set  = '0;
        ctr_clr_n  = 1'b1;
        case (state)
            CLR: ctr_clr_n = 1'b0;
            LOAD: begin
                for (int unsigned i = 0; i < NDIG; i++)
                    digit_set[4*i +: 4] = bcd_clamp(preset[4*i +: 4]);
            end
            RUN: begin
                if (count_en_c && !hold_term_c) begin
                    for (int unsigned i = 0; i < NDIG; i++)
                        if (adv_c[i])
                            digit_mode[2*i +: 2] = dir_r ? MODE_UP : MODE_DOWN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dir_r     <= 1'b0;
            load_pend <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            dir_r     <= dir_nxt;
            load_pend <= load_pend_nxt;
            running   <= (state_nxt == RUN);
            done      <= count_en_c && term_c;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench: two controllers (WRAP=0 and WRAP=1) share stimulus, each
// driving its own behavioural BCD counter chain; expectations go through a queue.
module tb_stopwatch_ctrl;

    localparam int unsigned NDIG = 4;

    logic        clk = 1'b0;
    logic        reset, tick, start, stop, clear, load_req, dir;
    logic [15:0] preset;
    logic [15:0] q0 = '0, q1 = '0;
    logic [7:0]  mode0, mode1;
    logic [15:0] set0, set1;
    logic        clrn0, clrn1, run0, run1, done0, done1;

    int          errors = 0;
    int          checks = 0;
    string       tag_q[$];
    logic [63:0] exp_q[$];

    stopwatch_ctrl #(.NDIG(NDIG), .WRAP(1'b0)) u_dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .load_req(load_req), .dir(dir), .preset(preset),
        .digit_q(q0), .digit_mode(mode0), .digit_set(set0),
        .ctr_clr_n(clrn0), .running(run0), .done(done0)
    );

    stopwatch_ctrl #(.NDIG(NDIG), .WRAP(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .load_req(load_req), .dir(dir), .preset(preset),
        .digit_q(q1), .digit_mode(mode1), .digit_set(set1),
        .ctr_clr_n(clrn1), .running(run1), .done(done1)
    );

    always #5 clk = ~clk;

    // External counter chain: clear, else parallel load of non-zero nibbles, else count.
    function automatic logic [15:0] cnt_next(input logic [15:0] q, input logic [7:0] m,
                                             input logic [15:0] s, input logic clrn);
        logic [15:0] r;
        logic [3:0]  d;
        r = q;
        if (!clrn) return 16'h0000;
        for (int i = 0; i < 4; i++) begin
            d = q[4*i +: 4];
            if (s[4*i +: 4] != 4'd0)
                r[4*i +: 4] = s[4*i +: 4];
            else if (m[2*i +: 2] == 2'b10)
                r[4*i +: 4] = (d == 4'd9) ? 4'd0 : 4'(d + 4'd1);
            else if (m[2*i +: 2] == 2'b00)
                r[4*i +: 4] = (d == 4'd0) ? 4'd9 : 4'(d - 4'd1);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        q0 <= cnt_next(q0, mode0, set0, clrn0);
        q1 <= cnt_next(q1, mode1, set1, clrn1);
    end

    task automatic expect_val(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic cmp(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] v);
        expect_val(tag, v);
        cmp(obs);
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0;
        clear = 1'b0; load_req = 1'b0; dir = 1'b0; preset = '0;

        #3;
        chk("rst_mode",  64'(mode0), 64'hFF);
        chk("rst_set",   64'(set0),  64'h0);
        chk("rst_clrn",  64'(clrn0), 64'h1);
        chk("rst_run",   64'(run0),  64'h0);
        chk("rst_done",  64'(done0), 64'h0);

        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Preset 0190, then count down three ticks.
        @(negedge clk); load_req = 1'b1; preset = 16'h0190;
        @(negedge clk); load_req = 1'b0; #1;
        chk("ld_clrn_low", 64'(clrn0), 64'h0);
        chk("ld_clr_mode", 64'(mode0), 64'hFF);
        @(negedge clk); #1;
        chk("ld_set",      64'(set0),  64'h0190);
        chk("ld_set_clrn", 64'(clrn0), 64'h1);
        @(negedge clk); #1;
        chk("ld_q",        64'(q0),    64'h0190);
        chk("ld_pause",    64'(run0),  64'h0);
        start = 1'b1; dir = 1'b0;
        @(negedge clk); start = 1'b0; #1;
        chk("dn_running",  64'(run0),  64'h1);
        tick = 1'b1; #1;
        chk("dn_mode0",    64'(mode0), 64'hF0);
        @(negedge clk); #1;
        chk("dn_mode1",    64'(mode0), 64'hFC);
        @(negedge clk);
        @(negedge clk); tick = 1'b0; #1;
        chk("dn_q0187",    64'(q0),    64'h0187);

        // Stop and tick together: stop wins, nothing counts.
        stop = 1'b1; tick = 1'b1; #1;
        chk("stoptick_mode", 64'(mode0), 64'hFF);
        @(negedge clk); stop = 1'b0; tick = 1'b0; #1;
        chk("stoptick_run",  64'(run0),  64'h0);
        chk("stoptick_q",    64'(q0),    64'h0187);

        // Up count across two carries: 0099 -> 0100.
        load_req = 1'b1; preset = 16'h0099;
        @(negedge clk); load_req = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("up_q0099", 64'(q0), 64'h0099);
        start = 1'b1; dir = 1'b1;
        @(negedge clk); start = 1'b0; tick = 1'b1; #1;
        chk("up_mode",  64'(mode0), 64'hEA);
        @(negedge clk); tick = 1'b0; #1;
        chk("up_q0100", 64'(q0),   64'h0100);
        chk("up_run",   64'(run0), 64'h1);

        // Down to zero, then terminal: hold and DONE with a one-cycle pulse.
        stop = 1'b1;
        @(negedge clk); stop = 1'b0; load_req = 1'b1; preset = 16'h0001;
        @(negedge clk); load_req = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("term_q0001", 64'(q0), 64'h0001);
        start = 1'b1; dir = 1'b0;
        @(negedge clk); start = 1'b0; tick = 1'b1; #1;
        chk("term_mode_dec", 64'(mode0), 64'hFC);
        @(negedge clk); #1;
        chk("term_q0000",    64'(q0),    64'h0000);
        chk("term_mode_hold",64'(mode0), 64'hFF);
        @(negedge clk); tick = 1'b0; #1;
        chk("term_done",     64'(done0), 64'h1);
        chk("term_run",      64'(run0),  64'h0);
        chk("term_q_stay",   64'(q0),    64'h0000);
        @(negedge clk); #1;
        chk("term_done_off", 64'(done0), 64'h0);
        tick = 1'b1; #1;
        chk("done_tick_mode", 64'(mode0), 64'hFF);
        tick = 1'b0;

        // Clear and start in the same cycle: clear wins, CLR then IDLE.
        clear = 1'b1; start = 1'b1;
        @(negedge clk); clear = 1'b0; start = 1'b0; #1;
        chk("cs_clrn_low", 64'(clrn0), 64'h0);
        chk("cs_run",      64'(run0),  64'h0);
        @(negedge clk); #1;
        chk("cs_idle_clrn", 64'(clrn0), 64'h1);
        chk("cs_idle_mode", 64'(mode0), 64'hFF);

        // Out-of-range preset clamps to 9999; then up terminal with and without wrap.
        load_req = 1'b1; preset = 16'hFFFF;
        @(negedge clk); load_req = 1'b0;
        @(negedge clk); #1;
        chk("clamp_set", 64'(set1), 64'h9999);
        @(negedge clk); #1;
        chk("wrap_q9999", 64'(q1), 64'h9999);
        chk("nowrap_q9999", 64'(q0), 64'h9999);
        start = 1'b1; dir = 1'b1;
        @(negedge clk); start = 1'b0; tick = 1'b1; #1;
        chk("wrap_mode",   64'(mode1), 64'hAA);
        chk("nowrap_mode", 64'(mode0), 64'hFF);
        @(negedge clk); tick = 1'b0; #1;
        chk("wrap_done",   64'(done1), 64'h1);
        chk("wrap_run",    64'(run1),  64'h1);
        chk("wrap_q0000",  64'(q1),    64'h0000);
        chk("nowrap_done", 64'(done0), 64'h1);
        chk("nowrap_run",  64'(run0),  64'h0);
        chk("nowrap_q",    64'(q0),    64'h9999);
        @(negedge clk); #1;
        chk("wrap_done_off", 64'(done1), 64'h0);
        start = 1'b1; dir = 1'b1;
        @(negedge clk); start = 1'b0; tick = 1'b1; #1;
        chk("wrap_mode_next", 64'(mode1), 64'hFE);
        chk("nowrap_rerun",   64'(run0),  64'h1);

        // Asynchronous reset mid-RUN takes effect without a clock edge.
        reset = 1'b0; #1;
        chk("arst_mode", 64'(mode1), 64'hFF);
        chk("arst_run",  64'(run1),  64'h0);
        chk("arst_clrn", 64'(clrn1), 64'h1);
        chk("arst_done", 64'(done1), 64'h0);
        chk("arst_mode0", 64'(mode0), 64'hFF);
        tick = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
